dmem_responder: RTL and testbench

// - Multi-cycle data-memory responder: the target end of the core's data-bus load/store interface.
// - Accepts one word request at a time over a valid/ready handshake and answers after LATENCY cycles.
// - Adds a one-cycle resp_valid pulse, an error flag and an optional memory-mapped output register.
// - Used in place of the zero-wait data memory when modelling slower memory.

---
 rtl/dmem_responder.sv | 130 +++++++++++++
 tb/tb_dmem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one valid/ready request at a time, answered after LATENCY cycles.
// Optional memory-mapped output register at IO_ADDR enabled by defining DMEM_RESP_MMIO_EN.
module dmem_responder #(
   parameter int unsigned DEPTH   = 64,
   parameter int unsigned LATENCY = 2,
   parameter logic [31:0] IO_ADDR = 32'hFFFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] io_out
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
`ifdef DMEM_RESP_MMIO_EN
   localparam logic        MMIO_EN  = 1'b1;
`else
   localparam logic        MMIO_EN  = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        r_state, w_state_n;
   logic [3:0]    r_cnt, w_cnt_n;
   logic          r_we;
   logic [31:0]   r_addr, r_wdata;
   logic [31:0]   r_resp_rdata;
   logic          r_resp_err;
   logic [31:0]   r_mem [DEPTH];

   logic          w_accept, w_commit;
   logic          w_c_we;
   logic [31:0]   w_c_addr, w_c_wdata;
   logic          w_misalign, w_oor, w_mmio_hit, w_err;
   logic [AW-1:0] w_idx;
   logic [31:0]   w_io_val;

   assign req_ready  = (r_state != S_WAIT);
   assign resp_valid = (r_state == S_RESP);
   assign resp_rdata = r_resp_rdata;
   assign resp_err   = r_resp_err;
   assign w_accept   = req_valid & req_ready;

   // With LATENCY=1 the commit edge is the accept edge, so the live request is used directly.
   assign w_c_we    = (LATENCY == 1) ? req_we    : r_we;
   assign w_c_addr  = (LATENCY == 1) ? req_addr  : r_addr;
   assign w_c_wdata = (LATENCY == 1) ? req_wdata : r_wdata;

   assign w_misalign = |w_c_addr[1:0];
   assign w_oor      = ({2'b00, w_c_addr[31:2]} >= 32'(DEPTH));
   assign w_mmio_hit = MMIO_EN & (w_c_addr == IO_ADDR);
   assign w_err      = w_misalign | (w_oor & ~w_mmio_hit);
   assign w_idx      = w_c_addr[AW+1:2];
   assign w_commit   = ~reset & (w_state_n == S_RESP);

   always_comb begin
      w_state_n = r_state;
      w_cnt_n   = r_cnt;
      case (r_state)
         S_IDLE, S_RESP: begin
            w_state_n = S_IDLE;
            if (w_accept) begin
               w_cnt_n = CNT_INIT;
               if (LATENCY == 1) w_state_n = S_RESP;
               else              w_state_n = S_WAIT;
            end
         end
         S_WAIT: begin
            // Counter reaches zero on the same edge that enters RESP.
            w_cnt_n = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) w_state_n = S_RESP;
         end
         default: w_state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
      end else begin
         r_state <= w_state_n;
         r_cnt   <= w_cnt_n;
         if (w_commit) begin
            r_resp_err <= w_err;
            if (w_err || w_c_we) r_resp_rdata <= '0;
            else if (w_mmio_hit)  r_resp_rdata <= w_io_val;
            else                  r_resp_rdata <= r_mem[w_idx];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_we    <= req_we;
         r_addr  <= req_addr;
         r_wdata <= req_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (w_commit && w_c_we && !w_err && !w_mmio_hit) r_mem[w_idx] <= w_c_wdata;
   end

`ifdef DMEM_RESP_MMIO_EN
   logic [31:0] r_io_out;

   always_ff @(posedge clk) begin
      if (reset)                                        r_io_out <= '0;
      else if (w_commit && w_c_we && w_mmio_hit && !w_err) r_io_out <= w_c_wdata;
   end

   assign io_out = r_io_out;
`else
   assign io_out = '0;
`endif

   assign w_io_val = io_out;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: table of single transactions on a DEPTH=64/LATENCY=2 instance,
// plus hand sequences for back-to-back, LATENCY=1 and reset-in-WAIT cases.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, req_ready, resp_valid, resp_err;
   logic [31:0] req_addr, req_wdata, resp_rdata, io_out;
   logic        b_req_valid, b_req_we, b_req_ready, b_resp_valid, b_resp_err;
   logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata, b_io_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH(64), .LATENCY(2), .IO_ADDR(32'hFFFC)) u_dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .io_out(io_out)
   );

   dmem_responder #(.DEPTH(64), .LATENCY(1), .IO_ADDR(32'hFFFC)) u_dut_l1 (
      .clk(clk), .reset(reset),
      .req_valid(b_req_valid), .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
      .req_ready(b_req_ready), .resp_valid(b_resp_valid), .resp_rdata(b_resp_rdata),
      .resp_err(b_resp_err), .io_out(b_io_out)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t tv[14];

`ifdef DMEM_RESP_MMIO_EN
   localparam logic        MMIO_ERR = 1'b0;
   localparam logic [31:0] MMIO_RD  = 32'hA5;
   localparam logic [31:0] MMIO_IO  = 32'hA5;
`else
   localparam logic        MMIO_ERR = 1'b1;
   localparam logic [31:0] MMIO_RD  = 32'h0;
   localparam logic [31:0] MMIO_IO  = 32'h0;
`endif

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic txn(input vec_t v, output logic [31:0] rd, output logic er,
                      output int lat, output logic rdy);
      @(negedge clk);
      req_valid = 1'b1; req_we = v.we; req_addr = v.addr; req_wdata = v.wdata;
      rdy = req_ready;
      @(posedge clk); #1;
      req_valid = 1'b0;
      lat = 0;
      while (!resp_valid && lat < 16) begin
         @(posedge clk); #1;
         lat++;
      end
      rd = resp_rdata;
      er = resp_err;
   endtask

   initial begin
      logic [31:0] rd;
      logic        er, rdy, seen;
      int          lat;
      logic [31:0] la[4];
      logic [31:0] lrd[4];
      int          rsp_cyc[4], acc_cyc[4];
      int          k, rk;

      tv[0]  = '{1'b1, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0};
      tv[1]  = '{1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      tv[2]  = '{1'b1, 32'h13,   32'h1234,     32'h0,        1'b1};
      tv[3]  = '{1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
      tv[4]  = '{1'b0, 32'h100,  32'h0,        32'h0,        1'b1};
      tv[5]  = '{1'b1, 32'hFC,   32'hCAFEF00D, 32'h0,        1'b0};
      tv[6]  = '{1'b0, 32'hFC,   32'h0,        32'hCAFEF00D, 1'b0};
      tv[7]  = '{1'b1, 32'h4,    32'h44444444, 32'h0,        1'b0};
      tv[8]  = '{1'b1, 32'h104,  32'h77,       32'h0,        1'b1};
      tv[9]  = '{1'b0, 32'h4,    32'h0,        32'h44444444, 1'b0};
      tv[10] = '{1'b0, 32'h102,  32'h0,        32'h0,        1'b1};
      tv[11] = '{1'b0, 32'h12,   32'h0,        32'h0,        1'b1};
      tv[12] = '{1'b1, 32'hFFFC, 32'hA5,       32'h0,        MMIO_ERR};
      tv[13] = '{1'b0, 32'hFFFC, 32'h0,        MMIO_RD,      MMIO_ERR};

      reset = 1'b1;
      req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_resp_valid", 32'(resp_valid), 32'd0);
      chk("reset_resp_rdata", resp_rdata, 32'd0);
      chk("reset_resp_err",   32'(resp_err), 32'd0);
      chk("reset_io_out",     io_out, 32'd0);
      chk("reset_req_ready",  32'(req_ready), 32'd1);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 14; i++) begin
         txn(tv[i], rd, er, lat, rdy);
         chk($sformatf("v%0d_ready", i), 32'(rdy), 32'd1);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd1);
         chk($sformatf("v%0d_rdata", i), rd, tv[i].exp_rd);
         chk($sformatf("v%0d_err", i), 32'(er), 32'(tv[i].exp_err));
         @(posedge clk); #1;
         chk($sformatf("v%0d_pulse_end", i), 32'(resp_valid), 32'd0);
      end
      chk("io_out_after_store", io_out, MMIO_IO);

      // req_valid held high across four loads
      la[0] = 32'h10; la[1] = 32'hFC; la[2] = 32'h4; la[3] = 32'h100;
      k = 0; rk = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (k < 4) begin
            req_valid = 1'b1; req_we = 1'b0; req_addr = la[k];
         end else begin
            req_valid = 1'b0;
         end
         rdy = req_ready;
         @(posedge clk);
         if (k < 4 && rdy) begin
            acc_cyc[k] = c;
            k++;
         end
         #1;
         if (resp_valid) begin
            if (rk < 4) begin
               rsp_cyc[rk] = c;
               lrd[rk] = resp_rdata;
            end
            rk++;
         end
      end
      req_valid = 1'b0;
      chk("b2b_accepts", 32'(k), 32'd4);
      chk("b2b_responses", 32'(rk), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (i < k)  chk($sformatf("b2b_acc_cyc%0d", i), 32'(acc_cyc[i]), 32'(2 * i));
         if (i < rk) chk($sformatf("b2b_rsp_cyc%0d", i), 32'(rsp_cyc[i]), 32'(2 * i + 1));
      end
      if (rk >= 4) begin
         chk("b2b_rd0", lrd[0], 32'hDEADBEEF);
         chk("b2b_rd1", lrd[1], 32'hCAFEF00D);
         chk("b2b_rd2", lrd[2], 32'h44444444);
         chk("b2b_rd3", lrd[3], 32'h0);
      end

      // LATENCY=1: store then load of 0x20 back-to-back
      @(negedge clk);
      b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 32'h20; b_req_wdata = 32'h55AA;
      chk("l1_ready_idle", 32'(b_req_ready), 32'd1);
      @(posedge clk); #1;
      chk("l1_resp0_valid", 32'(b_resp_valid), 32'd1);
      chk("l1_resp0_err", 32'(b_resp_err), 32'd0);
      chk("l1_resp0_rdata", b_resp_rdata, 32'd0);
      chk("l1_ready_resp", 32'(b_req_ready), 32'd1);
      b_req_we = 1'b0; b_req_wdata = '0;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      chk("l1_resp1_valid", 32'(b_resp_valid), 32'd1);
      chk("l1_resp1_err", 32'(b_resp_err), 32'd0);
      chk("l1_resp1_rdata", b_resp_rdata, 32'h55AA);
      @(posedge clk); #1;
      chk("l1_idle_valid", 32'(b_resp_valid), 32'd0);

      // reset while a store waits for its response
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h5;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rst_wait_ready", 32'(req_ready), 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("rst_no_resp", 32'(resp_valid), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_io_out", io_out, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      seen = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
         if (resp_valid) seen = 1'b1;
      end
      chk("rst_no_late_resp", 32'(seen), 32'd0);
      txn('{1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0}, rd, er, lat, rdy);
      chk("rst_reload_latency", 32'(lat), 32'd1);
      chk("rst_reload_rdata", rd, 32'hDEADBEEF);
      chk("rst_reload_err", 32'(er), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
